// File: rtl/mipi_rx_lane_deskew.sv
// -----------------------------------------------------------------------------
// mipi_rx_lane_deskew
//
// Realigns the per-lane byte streams coming out of the MIPI byte aligners so
// that byte k of every active lane is presented in the same cycle. Each lane
// keeps a short byte delay line. While the packet is arming, the block notes
// how many cycles after the first lane each lane's valid went high. Every lane
// is then delayed so that it lines up with the latest lane.
//
// Parameters
//   LANES        number of physical lanes (1..8)
//   ALIGN_DEPTH  largest tolerated inter-lane skew in byte clocks (1..7)
//
// Ports
//   clk_i           byte clock, the only clock
//   reset_n_i       asynchronous active-low reset
//   active_lanes_i  lanes in use; 0 or >LANES selects LANES; sampled in IDLE
//   bytes_valid_i   per-lane valid, bit i = lane i
//   byte_i          per-lane byte, lane i on [8i+7:8i]
//   lane_valid_o    aligned data valid
//   lane_byte_o     aligned bytes, same packing as byte_i; 0 when not valid
//   skew_err_o      one-cycle pulse on excessive skew or lane drop while arming
//   max_skew_o      skew of the latest lane of the current/last packet
// -----------------------------------------------------------------------------
module mipi_rx_lane_deskew #(
    parameter int LANES       = 4,
    parameter int ALIGN_DEPTH = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [3:0]         active_lanes_i,
    input  logic [LANES-1:0]   bytes_valid_i,
    input  logic [8*LANES-1:0] byte_i,
    output logic               lane_valid_o,
    output logic [8*LANES-1:0] lane_byte_o,
    output logic               skew_err_o,
    output logic [2:0]         max_skew_o
);

    // The arming counter needs one value past ALIGN_DEPTH (up to 8), so it is
    // one bit wider than the per-lane skew registers.
    localparam logic [3:0] CNT_SAT = 4'(ALIGN_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        ALIGNED,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [3:0]       n_lanes;     // lane count latched when arming starts
    logic [3:0]       cnt;         // cycles since the first lane went valid
    logic [LANES-1:0] seen;        // lanes whose valid has risen this packet
    logic [LANES-1:0] last_mask;   // lane(s) that rose last and define packet end
    logic [2:0]       skew      [LANES];
    logic [2:0]       dly       [LANES];
    logic [7:0]       dline     [LANES][ALIGN_DEPTH];

    logic [3:0]       n_req;
    logic [LANES-1:0] mask_req;
    logic [LANES-1:0] mask_lat;
    logic [LANES-1:0] mask_cur;
    logic [LANES-1:0] vld;
    logic [LANES-1:0] rise;
    logic             any_vld;
    logic             all_vld;
    logic             fell;
    logic             last_vld;
    logic [2:0]       entry_dly [LANES];
    logic [2:0]       sel_dly   [LANES];
    logic [7:0]       tap;
    logic [8*LANES-1:0] picked;

    // -------------------------------------------------------------------------
    // Lane masks, edge detection and delay-line tap selection
    // -------------------------------------------------------------------------
    always_comb begin
        n_req = active_lanes_i;
        if (active_lanes_i == 4'd0 || active_lanes_i > 4'(LANES)) begin
            n_req = 4'(LANES);
        end

        mask_req = '0;
        mask_lat = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_req[i] = (4'(i) < n_req);
            mask_lat[i] = (4'(i) < n_lanes);
        end

        // In IDLE the live request decides which lanes count; afterwards the
        // lane count latched at arming time is used.
        mask_cur = (state == IDLE) ? mask_req : mask_lat;
        vld      = bytes_valid_i & mask_cur;
        any_vld  = |vld;
        all_vld  = (vld == mask_cur);
        rise     = vld & ~seen;
        fell     = |(seen & ~vld);
        last_vld = |(bytes_valid_i & last_mask);

        picked = '0;
        tap    = '0;
        for (int i = 0; i < LANES; i++) begin
            // On entry to ALIGNED the latest lane's skew equals the current
            // count, so earlier lanes wait (count - own skew) cycles and lanes
            // rising now need no delay. In IDLE seen is empty, so every lane
            // gets zero delay.
            entry_dly[i] = rise[i] ? 3'd0 : (cnt[2:0] - skew[i]);
            sel_dly[i]   = (state == ALIGNED) ? dly[i] : entry_dly[i];

            // dline[i][k] holds the byte from k+1 cycles ago.
            tap = byte_i[8*i +: 8];
            for (int k = 0; k < ALIGN_DEPTH; k++) begin
                if (sel_dly[i] == 3'(k + 1)) begin
                    tap = dline[i][k];
                end
            end
            picked[8*i +: 8] = mask_cur[i] ? tap : 8'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane byte delay lines, shifting every cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < LANES; i++) begin
                for (int k = 0; k < ALIGN_DEPTH; k++) begin
                    dline[i][k] <= 8'd0;
                end
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                dline[i][0] <= byte_i[8*i +: 8];
                for (int k = 1; k < ALIGN_DEPTH; k++) begin
                    dline[i][k] <= dline[i][k-1];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Deskew FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            n_lanes      <= 4'(LANES);
            cnt          <= 4'd0;
            seen         <= '0;
            last_mask    <= '0;
            lane_valid_o <= 1'b0;
            lane_byte_o  <= '0;
            skew_err_o   <= 1'b0;
            max_skew_o   <= 3'd0;
            for (int i = 0; i < LANES; i++) begin
                skew[i] <= 3'd0;
                dly[i]  <= 3'd0;
            end
        end else begin
            skew_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    lane_valid_o <= 1'b0;
                    lane_byte_o  <= '0;
                    if (any_vld) begin
                        n_lanes <= n_req;
                        cnt     <= 4'd1;
                        for (int i = 0; i < LANES; i++) begin
                            skew[i] <= 3'd0;
                            dly[i]  <= 3'd0;
                        end
                        if (all_vld) begin
                            // Every lane arrived together: no skew to remove.
                            state        <= ALIGNED;
                            seen         <= '0;
                            last_mask    <= vld;
                            max_skew_o   <= 3'd0;
                            lane_valid_o <= 1'b1;
                            lane_byte_o  <= picked;
                        end else begin
                            state <= ARMING;
                            seen  <= vld;
                        end
                    end
                end

                ARMING: begin
                    lane_valid_o <= 1'b0;
                    lane_byte_o  <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        if (rise[i]) begin
                            skew[i] <= cnt[2:0];
                        end
                    end
                    if (fell || cnt == CNT_SAT) begin
                        // A lane this late (or a lane dropping out) cannot be
                        // aligned; abandon the packet until the lanes go quiet.
                        state      <= WAIT_IDLE;
                        seen       <= '0;
                        skew_err_o <= 1'b1;
                    end else if (all_vld) begin
                        state        <= ALIGNED;
                        seen         <= '0;
                        last_mask    <= rise;
                        max_skew_o   <= cnt[2:0];
                        for (int i = 0; i < LANES; i++) begin
                            dly[i] <= entry_dly[i];
                        end
                        lane_valid_o <= 1'b1;
                        lane_byte_o  <= picked;
                    end else begin
                        seen <= seen | rise;
                        if (cnt != CNT_SAT) begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                ALIGNED: begin
                    // Only the latest lane ends the packet; lanes that finish
                    // earlier keep being delayed out as they were.
                    if (last_vld) begin
                        lane_valid_o <= 1'b1;
                        lane_byte_o  <= picked;
                    end else begin
                        lane_valid_o <= 1'b0;
                        lane_byte_o  <= '0;
                        state        <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    lane_valid_o <= 1'b0;
                    lane_byte_o  <= '0;
                    if (!any_vld) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    lane_valid_o <= 1'b0;
                    lane_byte_o  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_rx_lane_deskew.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mipi_rx_lane_deskew (LANES=4, ALIGN_DEPTH=3).
// Each packet is described by per-lane start offsets and lengths. Expected
// output is derived from the deskew rules: the packet is aligned to the
// latest lane's start M. Lane i output at cycle c is the byte driven on lane i
// at cycle c-1-(M-s_i). The packet lasts as long as the latest lane stays
// valid. Skew beyond the depth produces an error pulse and no output.
// -----------------------------------------------------------------------------
module tb_mipi_rx_lane_deskew;

    localparam int LANES = 4;
    localparam int DEPTH = 3;
    localparam int MAXC  = 64;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [3:0]         active_lanes;
    logic [LANES-1:0]   bytes_valid;
    logic [8*LANES-1:0] bytes_in;
    logic               lane_valid;
    logic [8*LANES-1:0] lane_byte;
    logic               skew_err;
    logic [2:0]         max_skew;

    int checks = 0;
    int errors = 0;

    mipi_rx_lane_deskew #(
        .LANES       (LANES),
        .ALIGN_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .active_lanes_i (active_lanes),
        .bytes_valid_i  (bytes_valid),
        .byte_i         (bytes_in),
        .lane_valid_o   (lane_valid),
        .lane_byte_o    (lane_byte),
        .skew_err_o     (skew_err),
        .max_skew_o     (max_skew)
    );

    always #5 clk = ~clk;

    // Packet description
    int       s   [LANES];
    int       len [LANES];
    logic [3:0] act_code;
    bit       pat;

    // Recorded stimulus and responses, indexed by packet-relative cycle
    logic [7:0]         hist    [LANES][MAXC];
    logic               out_vld [MAXC];
    logic [8*LANES-1:0] out_byte[MAXC];
    logic               out_err [MAXC];
    logic [2:0]         out_max [MAXC];
    int                 prev_max;
    int                 pkt_id = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            bytes_valid = '0;
            bytes_in    = 32'($urandom);
        end
    endtask

    task automatic run_packet();
        int  n, m, l, t;
        bit  good;
        logic               ev, ee;
        logic [8*LANES-1:0] eb;
        int  exp_max;

        n = (act_code == 4'd0 || act_code > 4'(LANES)) ? LANES : int'(act_code);
        m = 0;
        t = 0;
        for (int i = 0; i < n; i++) begin
            if (s[i] > m) m = s[i];
            if (s[i] + len[i] > t) t = s[i] + len[i];
        end
        l = 0;
        for (int i = 0; i < n; i++) begin
            if (s[i] == m) l = len[i];
        end
        good = (m <= DEPTH);
        t = t + 4;

        for (int c = 0; c <= t; c++) begin
            @(negedge clk);
            out_vld[c]  = lane_valid;
            out_byte[c] = lane_byte;
            out_err[c]  = skew_err;
            out_max[c]  = max_skew;
            active_lanes = act_code;
            for (int i = 0; i < LANES; i++) begin
                logic [7:0] b;
                logic       v;
                b = 8'($urandom);
                if (i < n) begin
                    v = (c >= s[i] && c < s[i] + len[i]);
                    if (v && pat) b = 8'h10 + 8'(c - s[i]);
                end else begin
                    v = 1'($urandom_range(0, 1));
                end
                bytes_valid[i]    = v;
                bytes_in[8*i +: 8] = b;
                hist[i][c]        = b;
            end
        end

        for (int c = 0; c <= t; c++) begin
            ev = good && c >= m + 1 && c <= m + l;
            ee = !good && c == DEPTH + 2;
            eb = '0;
            if (ev) begin
                for (int i = 0; i < n; i++) begin
                    eb[8*i +: 8] = hist[i][c - 1 - m + s[i]];
                end
            end
            check($sformatf("pkt%0d c%0d valid", pkt_id, c), 32'(out_vld[c]), 32'(ev));
            check($sformatf("pkt%0d c%0d bytes", pkt_id, c), out_byte[c], eb);
            check($sformatf("pkt%0d c%0d skew_err", pkt_id, c), 32'(out_err[c]), 32'(ee));
        end
        exp_max = good ? m : prev_max;
        check($sformatf("pkt%0d max_skew", pkt_id), 32'(out_max[t]), 32'(exp_max));
        prev_max = exp_max;
        pkt_id++;
    endtask

    task automatic random_packet();
        int r, n, m, j, k, l;
        r = $urandom_range(0, 9);
        if (r < 7)       act_code = 4'($urandom_range(1, 4));
        else if (r == 7) act_code = 4'd0;
        else             act_code = 4'($urandom_range(5, 15));
        n = (act_code == 4'd0 || act_code > 4'(LANES)) ? LANES : int'(act_code);
        pat = 1'b0;
        if (n == 1) m = 0;
        else if ($urandom_range(0, 5) == 0) m = $urandom_range(DEPTH + 1, DEPTH + 2);
        else m = $urandom_range(0, DEPTH);
        for (int i = 0; i < LANES; i++) s[i] = (i < n) ? $urandom_range(0, m) : 0;
        j = $urandom_range(0, n - 1);
        k = (j + 1) % n;
        s[k] = 0;
        s[j] = m;
        l = $urandom_range(1, 8);
        for (int i = 0; i < LANES; i++) begin
            // Lanes tied for latest share one length so the packet end is unambiguous.
            if (s[i] == m) len[i] = l;
            else           len[i] = m - s[i] + 1 + $urandom_range(0, 6);
        end
        run_packet();
    endtask

    initial begin
        reset_n      = 1'b0;
        active_lanes = 4'd4;
        bytes_valid  = '0;
        bytes_in     = '0;
        prev_max     = 0;
        act_code     = 4'd4;
        pat          = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst lane_valid", 32'(lane_valid), 32'd0);
        check("rst lane_byte", lane_byte, 32'd0);
        check("rst skew_err", 32'(skew_err), 32'd0);
        check("rst max_skew", 32'(max_skew), 32'd0);
        reset_n = 1'b1;
        drive_idle(3);

        // All four lanes together, counting bytes
        s = '{0, 0, 0, 0}; len = '{6, 6, 6, 6};
        run_packet();
        check("together first valid", 32'(out_vld[1]), 32'd1);
        check("together first bytes", out_byte[1], 32'h10101010);
        check("together max_skew", 32'(out_max[1]), 32'd0);

        // Rises at 0,1,3,2
        s = '{0, 1, 3, 2}; len = '{6, 5, 5, 4};
        run_packet();
        check("skew3 not early", 32'(out_vld[3]), 32'd0);
        check("skew3 valid", 32'(out_vld[4]), 32'd1);
        check("skew3 bytes", out_byte[4], 32'h10101010);
        check("skew3 max_skew", 32'(out_max[4]), 32'd3);

        // Lane 2 four cycles late: error, then a clean packet
        pat = 1'b0;
        s = '{0, 0, 4, 0}; len = '{6, 6, 3, 6};
        run_packet();
        s = '{1, 0, 0, 2}; len = '{4, 5, 6, 3};
        run_packet();

        // Two active lanes, lanes 2/3 toggle garbage
        act_code = 4'd2;
        s = '{0, 2, 0, 0}; len = '{4, 5, 0, 0};
        run_packet();

        // Lane 0 ends two cycles before the latest lane
        act_code = 4'd4;
        pat = 1'b1;
        s = '{0, 0, 0, 1}; len = '{4, 5, 6, 5};
        run_packet();
        check("late end still valid", 32'(out_vld[6]), 32'd1);
        check("late end drop", 32'(out_vld[7]), 32'd0);

        // Single lane
        act_code = 4'd1;
        s = '{0, 0, 0, 0}; len = '{3, 0, 0, 0};
        run_packet();
        check("one lane latency", 32'(out_vld[1]), 32'd1);

        // Reset in the middle of an aligned packet, valids held through release
        act_code = 4'd4;
        active_lanes = 4'd4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bytes_valid = '1;
            bytes_in    = 32'($urandom);
        end
        @(negedge clk);
        check("pre-reset valid", 32'(lane_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async rst valid", 32'(lane_valid), 32'd0);
        check("async rst bytes", lane_byte, 32'd0);
        check("async rst max_skew", 32'(max_skew), 32'd0);
        @(negedge clk);
        bytes_in = 32'hA1B2C3D4;
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post-reset arm valid", 32'(lane_valid), 32'd1);
        check("post-reset arm bytes", lane_byte, 32'hA1B2C3D4);
        prev_max = 0;
        drive_idle(4);
        pat = 1'b0;
        s = '{2, 0, 1, 0}; len = '{5, 6, 5, 7};
        run_packet();

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            random_packet();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mipi_rx_lane_deskew.md
MIPI_RX_LANE_DESKEW -- requirements
Module: mipi_rx_lane_deskew

Interface
REQ-001 Parameter LANES, default 4: number of physical lanes; legal 1..8.
REQ-002 Parameter ALIGN_DEPTH, default 3: maximum tolerated inter-lane skew in byte clocks; legal 1..7.
REQ-003 clk_i  input  1  MIPI byte clock; the only clock.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 active_lanes_i  input  4  number of lanes in use, 1..LANES; 0 or >LANES means LANES; sampled only in IDLE.
REQ-006 bytes_valid_i  input  LANES  per-lane valid from the byte aligners; bit i belongs to lane i.
REQ-007 byte_i  input  8*LANES  per-lane byte; lane i on bits [8i+7:8i].
REQ-008 lane_valid_o  output  1  lane-aligned data valid.
REQ-009 lane_byte_o  output  8*LANES  lane-aligned bytes, same lane packing as byte_i.
REQ-010 skew_err_o  output  1  one-cycle pulse: skew exceeded ALIGN_DEPTH or a lane dropped during arming.
REQ-011 max_skew_o  output  3  skew in cycles of the latest lane for the current or last packet.

Function
REQ-012 Only lanes 0..N-1 take part (N = effective active_lanes_i); other lanes' valid is ignored and their lane_byte_o bits are 0.
REQ-013 Each active lane has an ALIGN_DEPTH-entry byte delay line that shifts every cycle.
REQ-014 States: IDLE, ARMING, ALIGNED, WAIT_IDLE.
REQ-015 IDLE: if any active valid is high, latch N, clear skew counter, record skew 0 for every valid lane, and go to ARMING; if all active valids are high in that cycle, go directly to ALIGNED.
REQ-016 ARMING: skew counter increments each cycle; a lane whose valid rises records the current count as its skew[i].
REQ-017 ARMING -> ALIGNED in the cycle the last active lane's valid rises; max_skew = that lane's skew.
REQ-018 ARMING -> WAIT_IDLE with skew_err_o pulse if the count reaches ALIGN_DEPTH+1 without all lanes valid, or if an already-valid lane's valid falls.
REQ-019 Alignment: lane i output is lane i input delayed by (max_skew - skew[i]) cycles, plus one output register.
REQ-020 lane_valid_o rises the cycle after the last lane's first valid byte; byte k of every lane appears in the same cycle.
REQ-021 ALIGNED: lane_valid_o follows the latest lane's valid delayed by one cycle; earlier-ending lanes do not end the packet.
REQ-022 When the latest lane's valid falls, lane_valid_o drops the following cycle and the state goes to WAIT_IDLE.
REQ-023 WAIT_IDLE -> IDLE once all active valids are low.
REQ-024 lane_byte_o is 0 in every cycle where lane_valid_o is 0.
REQ-025 max_skew_o updates on entry to ALIGNED and holds until the next entry.
REQ-026 With N=1 there is never skew: valid in IDLE gives ALIGNED directly with one-cycle latency.
REQ-027 skew counter saturates at ALIGN_DEPTH+1; skew[i] is 3 bits wide.

Reset
REQ-028 reset_n_i low asynchronously forces IDLE; lane_valid_o=0, lane_byte_o=0, skew_err_o=0, max_skew_o=0; delay lines and skews are cleared.
REQ-029 Reset asserted mid-packet drops lane_valid_o immediately. After release, the block resumes from IDLE; if valids are already high, it arms at that cycle.

Verification
REQ-030 LANES=4, N=4, all lanes rise together, bytes 0x10,0x11,... -> lane_valid_o high 1 cycle later, each output lane shows 0x10 in the same cycle, max_skew_o=0.
REQ-031 Lane valids rise at cycles 0,1,3,2 for lanes 0..3 -> lane_valid_o rises at cycle 4, byte 0 of all lanes is aligned, max_skew_o=3.
REQ-032 ALIGN_DEPTH=3, lane 2 rises 4 cycles after lane 0 -> skew_err_o single pulse, lane_valid_o stays 0, returns to IDLE after all valids are low, next clean packet aligns.
REQ-033 N=2 with lanes 2,3 toggling garbage -> lanes 2,3 outputs are 0, lanes 0/1 are aligned normally.
REQ-034 Packet end skew: lane 0 drops 2 cycles before lane 3 (latest) -> lane_valid_o drops 1 cycle after lane 3 drops, with no early truncation.
REQ-035 reset_n_i pulsed low during ALIGNED -> outputs are 0 immediately; the next packet aligns correctly.
